fpu_op_sequencer: RTL and testbench

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

---
 rtl/fpu_op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_op_sequencer
//  Description : Single-outstanding command sequencer in front of a
//                floating-point datapath. Latches operands, waits a
//                per-opcode latency, captures the selected result and
//                holds it until the response handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer #(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 4,
    parameter int LAT_CMP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_op,
    input  logic [31:0] alu_add_res,
    input  logic [31:0] alu_mul_res,
    input  logic [31:0] alu_div_res,
    input  logic        alu_cmp_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    // A latency of zero still needs one WAIT cycle to capture the result.
    localparam int c_lat_add = (LAT_ADD == 0) ? 1 : LAT_ADD;
    localparam int c_lat_mul = (LAT_MUL == 0) ? 1 : LAT_MUL;
    localparam int c_lat_div = (LAT_DIV == 0) ? 1 : LAT_DIV;
    localparam int c_lat_cmp = (LAT_CMP == 0) ? 1 : LAT_CMP;

    // Counter preload: the WAIT cycle that sees zero is the capture cycle.
    localparam logic [3:0] c_cnt_add = 4'(c_lat_add - 1);
    localparam logic [3:0] c_cnt_mul = 4'(c_lat_mul - 1);
    localparam logic [3:0] c_cnt_div = 4'(c_lat_div - 1);
    localparam logic [3:0] c_cnt_cmp = 4'(c_lat_cmp - 1);

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_mul = 3'd2;
    localparam logic [2:0] c_op_div = 3'd3;
    localparam logic [2:0] c_op_cmp = 3'd4;

    // The 4-bit counter cannot represent latencies beyond 15.
    generate
        if (LAT_ADD > 15 || LAT_MUL > 15 || LAT_DIV > 15 || LAT_CMP > 15 ||
            LAT_ADD < 0  || LAT_MUL < 0  || LAT_DIV < 0  || LAT_CMP < 0) begin : g_lat_range_err
            $error("fpu_op_sequencer: LAT_* parameters must lie in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_cnt_load;
    logic [31:0] w_result;

    assign w_illegal = (cmd_op > c_op_cmp);

    // State register; reset always returns to IDLE and drops any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status outputs, decoded from the current state.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        cmd_ready = rst;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                w_accept  = cmd_valid;
                if (cmd_valid) begin
                    w_next = w_illegal ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Per-opcode counter preload and result selection for the latched opcode.
    always_comb begin
        w_cnt_load = 4'd0;
        case (cmd_op)
            c_op_add, c_op_sub: w_cnt_load = c_cnt_add;
            c_op_mul:           w_cnt_load = c_cnt_mul;
            c_op_div:           w_cnt_load = c_cnt_div;
            c_op_cmp:           w_cnt_load = c_cnt_cmp;
            default:            w_cnt_load = 4'd0;
        endcase
        w_result = 32'd0;
        case (r_op)
            c_op_add, c_op_sub: w_result = alu_add_res;
            c_op_mul:           w_result = alu_mul_res;
            c_op_div:           w_result = alu_div_res;
            c_op_cmp:           w_result = {31'd0, alu_cmp_res};
            default:            w_result = 32'd0;
        endcase
    end

    // Operand latching on accept, latency countdown, and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in1  <= 32'd0;
            alu_in2  <= 32'd0;
            alu_op   <= 1'b0;
            r_op     <= 3'd0;
            r_cnt    <= 4'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_in1 <= cmd_a;
                alu_in2 <= cmd_b;
                alu_op  <= (cmd_op == c_op_sub);
                r_op    <= cmd_op;
                if (w_illegal) begin
                    // Illegal opcodes answer immediately with an error response.
                    r_cnt    <= 4'd0;
                    rsp_data <= 32'd0;
                    rsp_err  <= 1'b1;
                end else begin
                    r_cnt <= w_cnt_load;
                end
            end else if (r_state == WAIT) begin
                if (r_cnt == 4'd0) begin
                    rsp_data <= w_result;
                    rsp_err  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_op_sequencer
//  Description : Self-checking bench for fpu_op_sequencer with a behavioural
//                floating-point datapath behind the alu_* ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_op_sequencer;

    localparam int LAT_ADD = 1;
    localparam int LAT_MUL = 2;
    localparam int LAT_DIV = 4;
    localparam int LAT_CMP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        alu_op;
    logic [31:0] alu_add_res;
    logic [31:0] alu_mul_res;
    logic [31:0] alu_div_res;
    logic        alu_cmp_res;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fpu_op_sequencer #(
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_CMP(LAT_CMP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_add_res(alu_add_res), .alu_mul_res(alu_mul_res),
        .alu_div_res(alu_div_res), .alu_cmp_res(alu_cmp_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-precision bits to real (normals, zero, inf/nan; denormals flush to zero).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)        d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF)  d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                         d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real to single-precision bits (truncating; out-of-range saturates to inf/zero).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        if (e <= 0)              return {d[63], 31'd0};
        if (e >= 255)            return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // Datapath stand-in driven by the sequencer's operand outputs.
    always_comb begin
        alu_add_res = alu_op ? r2f(f2r(alu_in1) - f2r(alu_in2)) : r2f(f2r(alu_in1) + f2r(alu_in2));
        alu_mul_res = r2f(f2r(alu_in1) * f2r(alu_in2));
        alu_div_res = r2f(f2r(alu_in1) / f2r(alu_in2));
        alu_cmp_res = f2r(alu_in1) > f2r(alu_in2);
    end

    // Reference model: what a command should return and after how many edges.
    function automatic logic [31:0] model_data(input logic [2:0] op, input logic [31:0] a, b);
        case (op)
            3'd0:    return r2f(f2r(a) + f2r(b));
            3'd1:    return r2f(f2r(a) - f2r(b));
            3'd2:    return r2f(f2r(a) * f2r(b));
            3'd3:    return r2f(f2r(a) / f2r(b));
            3'd4:    return {31'd0, f2r(a) > f2r(b)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int eff_lat(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    // Edges after the accept edge before rsp_valid is seen; illegal ops land in DONE on the accept edge itself.
    function automatic int model_lat(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return eff_lat(LAT_ADD);
            3'd2:       return eff_lat(LAT_MUL);
            3'd3:       return eff_lat(LAT_DIV);
            3'd4:       return eff_lat(LAT_CMP);
            default:    return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full command: accept, ignored extra command while busy, latency, hold, handshake.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                          input int hold, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic exp_aluop);
        int n;
        int nbusy;
        chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        rsp_ready = (hold == 0);
        tick();
        cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
        n = 0;
        nbusy = 0;
        while (!rsp_valid && n < 40) begin
            chk({tag, " cmd_ready_wait"}, 32'(cmd_ready), 32'd0);
            if (busy) nbusy++;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) rsp_ready = 1'b1;
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " rsp_data"}, rsp_data, exp_data);
            chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, " alu_in1"}, alu_in1, a);
            chk({tag, " alu_in2"}, alu_in2, b);
            chk({tag, " alu_op"}, 32'(alu_op), 32'(exp_aluop));
            chk({tag, " cmd_ready_done"}, 32'(cmd_ready), 32'd0);
            if (busy) nbusy++;
            tick();
        end
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid_exit"}, 32'(rsp_valid), 32'd0);
        chk({tag, " cmd_ready_exit"}, 32'(cmd_ready), 32'd1);
        chk({tag, " busy_exit"}, 32'(busy), 32'd0);
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_lat + hold + 1));
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic        aluop;
    } vec_t;

    vec_t vt[10];

    initial begin
        // Directed vectors with hand-computed single-precision results.
        vt[0] = '{"add_1p2",    3'd0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 1'b0, 1, 1'b0};
        vt[1] = '{"div_6d2",    3'd3, 32'h40C00000, 32'h40000000, 0, 32'h40400000, 1'b0, 4, 1'b0};
        vt[2] = '{"mul_bp",     3'd2, 32'h40000000, 32'h40400000, 6, 32'h40C00000, 1'b0, 2, 1'b0};
        vt[3] = '{"illegal6",   3'd6, 32'h3F800000, 32'h40000000, 0, 32'h00000000, 1'b1, 0, 1'b0};
        vt[4] = '{"cmp_2gt1",   3'd4, 32'h40000000, 32'h3F800000, 0, 32'h00000001, 1'b0, 1, 1'b0};
        vt[5] = '{"sub_2m1",    3'd1, 32'h40000000, 32'h3F800000, 0, 32'h3F800000, 1'b0, 1, 1'b1};
        vt[6] = '{"cmp_1gt2",   3'd4, 32'h3F800000, 32'h40000000, 2, 32'h00000000, 1'b0, 1, 1'b0};
        vt[7] = '{"illegal5bp", 3'd5, 32'h12345678, 32'h9ABCDEF0, 3, 32'h00000000, 1'b1, 0, 1'b0};
        vt[8] = '{"add_1p5",    3'd0, 32'h3FC00000, 32'h40200000, 1, 32'h40800000, 1'b0, 1, 1'b0};
        vt[9] = '{"mul_neg",    3'd2, 32'hC0000000, 32'h40400000, 0, 32'hC0C00000, 1'b0, 2, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset alu_in1", alu_in1, 32'd0);
        chk("reset alu_in2", alu_in2, 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_cmd(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].hold,
                   vt[i].data, vt[i].err, vt[i].lat, vt[i].aluop);
        end

        // Reset two cycles into a divide, with a command offered during reset.
        begin
            int seen;
            cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 32'h40C00000; cmd_b = 32'h40000000;
            rsp_ready = 1'b1;
            tick();
            cmd_valid = 1'b0;
            tick();
            tick();
            rst = 1'b1;
            cmd_valid = 1'b1; cmd_op = 3'd0;
            tick();
            rst = 1'b0;
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst rsp_data", rsp_data, 32'd0);
            chk("midrst rsp_err", 32'(rsp_err), 32'd0);
            chk("midrst alu_in1", alu_in1, 32'd0);
            chk("midrst alu_in2", alu_in2, 32'd0);
            chk("midrst alu_op", 32'(alu_op), 32'd0);
            chk("midrst busy", 32'(busy), 32'd0);
            chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (rsp_valid || busy) seen++;
                tick();
            end
            chk("midrst no_response", 32'(seen), 32'd0);
            do_cmd("after_rst_add", 3'd0, 32'h3F800000, 32'h40000000, 0,
                   32'h40400000, 1'b0, 1, 1'b0);
        end

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          gap;
            op  = 3'($urandom_range(0, 7));
            a   = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
            b   = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            do_cmd("rand", op, a, b, $urandom_range(0, 3), model_data(op, a, b),
                   (op > 3'd4), model_lat(op), (op == 3'd1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
